// File: rtl/utemporal_pkg.sv
// Shared definitions for the unary-temporal array border registers.
package utemporal_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  // Magnitude and window length drop the sign bit of the signed operand width.
  function automatic int mag_w(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/oreg_border_tdec.sv
// Output border: counts 1s of a unary bitstream over an L-cycle window, reapplies sign; result L+1 cycles after start.
// No backpressure: en=0 freezes the window (o_valid drops), clr abandons it without a pulse.
module oreg_border_tdec
  import utemporal_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    i_start,
  input  logic [mag_w(WIDTH)-1:0] i_len,
  input  logic                    i_sign,
  input  logic                    i_bit,
  output logic                    o_busy,
  output logic                    o_valid,
  output logic signed [WIDTH-1:0] o_data
);

  localparam int MW = mag_w(WIDTH);

  state_t                  state_q, state_d;
  logic [MW-1:0]           cnt_q, cnt_d;
  logic [MW-1:0]           acc_q, acc_d;
  logic                    sign_q, sign_d;
  logic signed [WIDTH-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic [MW-1:0]           sum;
  logic [WIDTH-1:0]        mag;

  // sum never exceeds the window length, so MW bits always suffice.
  assign sum = acc_q + MW'(i_bit);
  assign mag = {1'b0, sum};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sign_d  = sign_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      sign_d  = 1'b0;
      data_d  = '0;
    end else if (en) begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            sign_d = i_sign;
            cnt_d  = i_len;
            acc_d  = '0;
            if (i_len == '0) begin
              data_d  = '0;
              valid_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (cnt_q != MW'(1)) begin
            acc_d = sum;
            cnt_d = cnt_q - MW'(1);
          end else begin
            data_d  = sign_q ? -mag : mag;
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sign_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sign_q  <= sign_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_busy  = (state_q == RUN);
  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule

// File: tb/tb_oreg_border_tdec.sv
// Directed bench for oreg_border_tdec with a result scoreboard.
module tb_oreg_border_tdec;

  localparam int WIDTH = 16;

  logic                    clk = 1'b0;
  logic                    rst_n, en, clr, i_start, i_sign, i_bit;
  logic [WIDTH-2:0]        i_len;
  logic                    o_busy, o_valid;
  logic signed [WIDTH-1:0] o_data;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_pulses = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  oreg_border_tdec #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .i_start (i_start),
    .i_len   (i_len),
    .i_sign  (i_sign),
    .i_bit   (i_bit),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .o_data  (o_data)
  );

  always @(negedge clk) if (o_valid === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic start_win(input logic [WIDTH-2:0] len, input logic sign,
                           input logic push, input logic [WIDTH-1:0] expv);
    i_start = 1'b1;
    i_len   = len;
    i_sign  = sign;
    if (push) exp_q.push_back(expv);
    step();
    i_start = 1'b0;
  endtask

  // Drive n bits (bit k from bits[k%64]); busy must be high before every one.
  task automatic feed(input string tag, input int n, input logic [63:0] bits);
    for (int k = 0; k < n; k++) begin
      chk({tag, "_busy"}, 32'(o_busy), 32'd1);
      i_bit = bits[k % 64];
      step();
    end
  endtask

  task automatic check_result(input string tag);
    logic [WIDTH-1:0] e;
    exp_pulses++;
    chk({tag, "_vld"}, 32'(o_valid), 32'd1);
    chk({tag, "_busy_done"}, 32'(o_busy), 32'd0);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_dat"}, 32'(unsigned'(o_data)), 32'(e));
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; i_start = 1'b0;
    i_len = '0; i_sign = 1'b0; i_bit = 1'b1;

    // Reset and idle with bits but no start
    step(); step();
    chk("rst_dat", 32'(unsigned'(o_data)), 32'd0);
    chk("rst_vld", 32'(o_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    rst_n = 1'b1;
    step(); step(); step();
    chk("idle_dat", 32'(unsigned'(o_data)), 32'd0);
    chk("idle_vld", 32'(o_valid), 32'd0);
    chk("idle_busy", 32'(o_busy), 32'd0);

    // Positive decode: bits 1,1,0,1,0,0,1,1 -> +5
    start_win(15'd8, 1'b0, 1'b1, 16'd5);
    feed("pos", 8, 64'hCB);
    check_result("pos");
    step();
    chk("pos_pulse_end", 32'(o_valid), 32'd0);
    chk("pos_hold", 32'(unsigned'(o_data)), 32'd5);

    // Negative full scale, then negative zero
    start_win(15'd32767, 1'b1, 1'b1, 16'h8001);
    feed("full", 32767, {64{1'b1}});
    check_result("full");
    step();
    start_win(15'd5, 1'b1, 1'b1, 16'd0);
    feed("negz", 5, 64'h0);
    check_result("negz");
    step();

    // en stall after two bits with i_bit held high; bits 1,1,0,1 -> +3
    start_win(15'd4, 1'b0, 1'b1, 16'd3);
    feed("stall_a", 2, 64'h3);
    en = 1'b0; i_bit = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_busy", 32'(o_busy), 32'd1);
      chk("stall_vld", 32'(o_valid), 32'd0);
    end
    en = 1'b1;
    feed("stall_b", 2, 64'h2);
    check_result("stall");
    en = 1'b0;
    step();
    chk("stall_vld_off", 32'(o_valid), 32'd0);
    chk("stall_dat_hold", 32'(unsigned'(o_data)), 32'd3);
    en = 1'b1;
    step();

    // clr mid-window abandons it
    start_win(15'd6, 1'b1, 1'b0, 16'd0);
    feed("clr", 3, 64'h7);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_busy", 32'(o_busy), 32'd0);
    chk("clr_vld", 32'(o_valid), 32'd0);
    chk("clr_dat", 32'(unsigned'(o_data)), 32'd0);
    step(); step(); step();
    chk("clr_no_pulse", 32'(o_valid), 32'd0);

    // Back-to-back: new start in the o_valid cycle
    start_win(15'd1, 1'b0, 1'b1, 16'd1);
    feed("b2b_a", 1, 64'h1);
    check_result("b2b_a");
    start_win(15'd2, 1'b1, 1'b1, 16'hFFFE);
    feed("b2b_b", 1, 64'h1);
    i_bit = 1'b1;
    step();
    check_result("b2b_b");

    // Zero-length window
    start_win(15'd0, 1'b1, 1'b1, 16'd0);
    check_result("len0");
    step();
    chk("len0_pulse_end", 32'(o_valid), 32'd0);

    // i_start during RUN is ignored; bits 1,0,1 -> +2
    start_win(15'd3, 1'b0, 1'b1, 16'd2);
    i_start = 1'b1; i_len = 15'd0; i_sign = 1'b1;
    feed("ign", 3, 64'h5);
    i_start = 1'b0;
    check_result("ign");
    step();

    // Async reset mid-window
    start_win(15'd5, 1'b1, 1'b0, 16'd0);
    feed("arst", 2, 64'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_vld", 32'(o_valid), 32'd0);
    chk("arst_dat", 32'(unsigned'(o_data)), 32'd0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("arst_no_pulse", 32'(o_valid), 32'd0);

    chk("pulse_count", 32'(pulses), 32'(exp_pulses));
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
